// File: rtl/usb_spi_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : usb_spi_arbiter
//  Description : Two-requester round-robin arbiter in front of a MAX3421E SPI
//                byte engine. Each granted transaction sends a command byte
//                and one data byte under a single chip-select assertion, with
//                a per-byte timeout and a minimum chip-select gap afterwards.
//  Revision    : 1.0 - initial release
// ============================================================================
module usb_spi_arbiter #(
   parameter int SS_GAP  = 2,
   parameter int TIMEOUT = 255
) (
   input  logic            clk_in,
   input  logic            rst_in,
   input  logic [1:0]      req_in,
   input  logic [1:0][4:0] reg_in,
   input  logic [1:0]      wr_in,
   input  logic [1:0][7:0] wdata_in,
   output logic [1:0]      ack_out,
   output logic [7:0]      rdata_out,
   output logic            err_out,
   output logic            spi_start_out,
   output logic [7:0]      spi_tx_out,
   input  logic            spi_done_in,
   input  logic [7:0]      spi_rx_in,
   output logic            ss_out,
   output logic            busy_out
);

   localparam logic [2:0]  c_ST_IDLE  = 3'd0;
   localparam logic [2:0]  c_ST_SETUP = 3'd1;
   localparam logic [2:0]  c_ST_CMD   = 3'd2;
   localparam logic [2:0]  c_ST_DATA  = 3'd3;
   localparam logic [2:0]  c_ST_GAP   = 3'd4;

   // Last count value before the byte is declared lost / the gap is over.
   localparam logic [15:0] c_TO_LAST  = 16'(TIMEOUT - 1);
   localparam logic [3:0]  c_GAP_LAST = 4'(SS_GAP - 1);

   logic [2:0]  r_state;
   logic [2:0]  w_state_nxt;

   logic        r_grant;      // requester owning the current transaction
   logic        r_last;       // requester granted most recently
   logic [4:0]  r_reg;
   logic        r_wr;
   logic [7:0]  r_wdata;
   logic [15:0] r_to_cnt;
   logic [3:0]  r_gap_cnt;

   logic        r_ss;
   logic        r_start;
   logic [7:0]  r_tx;
   logic [1:0]  r_ack;
   logic        r_err;
   logic [7:0]  r_rdata;

   logic        w_any_req;
   logic        w_pick;
   logic        w_timeout;
   logic        w_ss_nxt;
   logic        w_start_nxt;
   logic [7:0]  w_tx_nxt;
   logic [1:0]  w_ack_nxt;
   logic        w_err_nxt;
   logic [7:0]  w_rdata_nxt;

   assign w_any_req = |req_in;
   // On contention the requester not served last wins; a lone request always wins.
   assign w_pick    = (req_in == 2'b11) ? ~r_last : req_in[1];
   assign w_timeout = (r_to_cnt == c_TO_LAST);

   assign ss_out        = r_ss;
   assign spi_start_out = r_start;
   assign spi_tx_out    = r_tx;
   assign ack_out       = r_ack;
   assign err_out       = r_err;
   assign rdata_out     = r_rdata;
   assign busy_out      = (r_state != c_ST_IDLE);

   // State register.
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         r_state <= c_ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic; a done coinciding with timeout expiry counts as a done.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_ST_IDLE:  if (w_any_req) w_state_nxt = c_ST_SETUP;
         c_ST_SETUP: w_state_nxt = c_ST_CMD;
         c_ST_CMD: begin
            if (spi_done_in)    w_state_nxt = c_ST_DATA;
            else if (w_timeout) w_state_nxt = c_ST_GAP;
         end
         c_ST_DATA:  if (spi_done_in || w_timeout) w_state_nxt = c_ST_GAP;
         c_ST_GAP:   if (r_gap_cnt == c_GAP_LAST) w_state_nxt = c_ST_IDLE;
         default:    w_state_nxt = c_ST_IDLE;
      endcase
   end

   // Output decode: next values of the registered SPI and handshake outputs.
   always_comb begin
      w_ss_nxt    = r_ss;
      w_start_nxt = 1'b0;
      w_tx_nxt    = r_tx;
      w_ack_nxt   = 2'b00;
      w_err_nxt   = 1'b0;
      w_rdata_nxt = r_rdata;
      case (r_state)
         c_ST_IDLE: begin
            if (w_any_req) w_ss_nxt = 1'b0;
         end
         c_ST_SETUP: begin
            w_start_nxt = 1'b1;
            w_tx_nxt    = {r_reg, 1'b0, r_wr, 1'b0};
         end
         c_ST_CMD: begin
            if (spi_done_in) begin
               w_start_nxt = 1'b1;
               w_tx_nxt    = r_wr ? r_wdata : 8'h00;
            end else if (w_timeout) begin
               w_ss_nxt           = 1'b1;
               w_ack_nxt[r_grant] = 1'b1;
               w_err_nxt          = 1'b1;
               w_rdata_nxt        = 8'hFF;
            end
         end
         c_ST_DATA: begin
            if (spi_done_in) begin
               w_ss_nxt           = 1'b1;
               w_ack_nxt[r_grant] = 1'b1;
               if (!r_wr) w_rdata_nxt = spi_rx_in;
            end else if (w_timeout) begin
               w_ss_nxt           = 1'b1;
               w_ack_nxt[r_grant] = 1'b1;
               w_err_nxt          = 1'b1;
               w_rdata_nxt        = 8'hFF;
            end
         end
         c_ST_GAP: begin
            w_ss_nxt = 1'b1;
         end
         default: begin
            w_ss_nxt = 1'b1;
         end
      endcase
   end

   // Datapath: output registers, request latch at grant, byte and gap counters.
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         r_ss      <= 1'b1;
         r_start   <= 1'b0;
         r_tx      <= 8'h00;
         r_ack     <= 2'b00;
         r_err     <= 1'b0;
         r_rdata   <= 8'h00;
         r_grant   <= 1'b0;
         r_last    <= 1'b1;
         r_reg     <= 5'd0;
         r_wr      <= 1'b0;
         r_wdata   <= 8'h00;
         r_to_cnt  <= 16'd0;
         r_gap_cnt <= 4'd0;
      end else begin
         r_ss    <= w_ss_nxt;
         r_start <= w_start_nxt;
         r_tx    <= w_tx_nxt;
         r_ack   <= w_ack_nxt;
         r_err   <= w_err_nxt;
         r_rdata <= w_rdata_nxt;

         if (r_state == c_ST_IDLE && w_any_req) begin
            r_grant <= w_pick;
            r_last  <= w_pick;
            r_reg   <= reg_in[w_pick];
            r_wr    <= wr_in[w_pick];
            r_wdata <= wdata_in[w_pick];
         end

         // Zero in the cycle the start pulse is visible, so the count equals
         // cycles elapsed since spi_start_out.
         if (w_start_nxt) begin
            r_to_cnt <= 16'd0;
         end else if (r_state == c_ST_CMD || r_state == c_ST_DATA) begin
            r_to_cnt <= r_to_cnt + 16'd1;
         end

         if (r_state == c_ST_GAP) begin
            r_gap_cnt <= r_gap_cnt + 4'd1;
         end else begin
            r_gap_cnt <= 4'd0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_usb_spi_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_usb_spi_arbiter
//  Description : Directed scoreboard bench for usb_spi_arbiter with a simple
//                SPI byte-engine model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_usb_spi_arbiter;

   localparam int SS_GAP  = 2;
   localparam int TIMEOUT = 32;
   localparam int BUDGET  = 2000;

   logic            clk_in = 1'b0;
   logic            rst_in;
   logic [1:0]      req_in;
   logic [1:0][4:0] reg_in;
   logic [1:0]      wr_in;
   logic [1:0][7:0] wdata_in;
   logic [1:0]      ack_out;
   logic [7:0]      rdata_out;
   logic            err_out;
   logic            spi_start_out;
   logic [7:0]      spi_tx_out;
   logic            spi_done_in;
   logic [7:0]      spi_rx_in;
   logic            ss_out;
   logic            busy_out;

   usb_spi_arbiter #(.SS_GAP(SS_GAP), .TIMEOUT(TIMEOUT)) dut (
      .clk_in        (clk_in),
      .rst_in        (rst_in),
      .req_in        (req_in),
      .reg_in        (reg_in),
      .wr_in         (wr_in),
      .wdata_in      (wdata_in),
      .ack_out       (ack_out),
      .rdata_out     (rdata_out),
      .err_out       (err_out),
      .spi_start_out (spi_start_out),
      .spi_tx_out    (spi_tx_out),
      .spi_done_in   (spi_done_in),
      .spi_rx_in     (spi_rx_in),
      .ss_out        (ss_out),
      .busy_out      (busy_out)
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      logic [1:0] ack;
      logic       err;
      logic [7:0] rdata;
   } exp_t;

   exp_t       exp_q[$];
   logic [7:0] tx_q[$];
   int         checks   = 0;
   int         failures = 0;
   int         cyc      = 0;

   // SPI model controls
   int         model_dly   = 8;
   bit         model_never = 1'b0;
   logic [7:0] model_rx    = 8'h00;

   always @(posedge clk_in) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      failures++;
      $display("FAIL %s actual=event expected=none", name);
   endtask

   // SPI byte engine: done model_dly cycles after each start, unless muted.
   initial begin
      spi_done_in = 1'b0;
      spi_rx_in   = 8'h00;
      forever begin
         @(negedge clk_in);
         while (spi_start_out && !model_never) begin
            repeat (model_dly) @(negedge clk_in);
            spi_done_in = 1'b1;
            spi_rx_in   = model_rx;
            @(negedge clk_in);
            spi_done_in = 1'b0;
         end
      end
   end

   // Monitor: pops expected bytes on each start and expected completions on each ack.
   initial begin
      int   last_start = 0;
      int   hi_run     = 0;
      bit   seen_low   = 1'b0;
      exp_t e;
      forever begin
         @(negedge clk_in);
         if (spi_start_out) begin
            last_start = cyc;
            if (tx_q.size() == 0) fail_now("unexpected_spi_start");
            else chk("spi_tx_byte", spi_tx_out, tx_q.pop_front());
            chk("ss_low_at_start", ss_out, 1'b0);
         end
         if (err_out && ack_out == 2'b00) fail_now("err_without_ack");
         if (ack_out != 2'b00) begin
            if (exp_q.size() == 0) begin
               fail_now("unexpected_ack");
            end else begin
               e = exp_q.pop_front();
               chk("ack_vector", ack_out, e.ack);
               chk("err_flag", err_out, e.err);
               chk("rdata", rdata_out, e.rdata);
               chk("ss_high_at_ack", ss_out, 1'b1);
               if (e.err) chk("timeout_latency", cyc - last_start, TIMEOUT);
            end
         end
         if (ss_out) begin
            hi_run++;
         end else begin
            if (hi_run != 0 && seen_low) chk("ss_gap_min", (hi_run >= SS_GAP), 1'b1);
            hi_run   = 0;
            seen_low = 1'b1;
         end
      end
   end

   task automatic push_exp(input logic [1:0] ack, input logic err, input logic [7:0] rd);
      exp_t e;
      e.ack = ack; e.err = err; e.rdata = rd;
      exp_q.push_back(e);
   endtask

   task automatic set_req(input int idx, input logic [4:0] r, input logic w, input logic [7:0] d);
      reg_in[idx]   = r;
      wr_in[idx]    = w;
      wdata_in[idx] = d;
      req_in[idx]   = 1'b1;
   endtask

   // Requester side: hold the request until its ack, then drop it.
   task automatic wait_ack(input int idx);
      int n = 0;
      do begin
         @(negedge clk_in);
         n++;
      end while (!ack_out[idx] && n < BUDGET);
      if (!ack_out[idx]) fail_now("ack_wait_expired");
      req_in[idx] = 1'b0;
   endtask

   initial begin
      rst_in   = 1'b0;
      req_in   = 2'b00;
      reg_in   = '0;
      wr_in    = 2'b00;
      wdata_in = '0;
      repeat (3) @(negedge clk_in);
      chk("rst_ss", ss_out, 1'b1);
      chk("rst_busy", busy_out, 1'b0);
      chk("rst_ack", ack_out, 2'b00);
      chk("rst_err", err_out, 1'b0);
      chk("rst_start", spi_start_out, 1'b0);
      chk("rst_tx", spi_tx_out, 8'h00);
      chk("rst_rdata", rdata_out, 8'h00);
      rst_in = 1'b1;
      repeat (2) @(negedge clk_in);

      // Write from requester 0: reg 17, data 0x20.
      model_dly = 8;
      tx_q.push_back(8'h8A); tx_q.push_back(8'h20);
      push_exp(2'b01, 1'b0, 8'h00);
      set_req(0, 5'd17, 1'b1, 8'h20);
      wait_ack(0);
      repeat (5) @(negedge clk_in);

      // Read from requester 1: reg 25, returns 0x5C.
      model_rx = 8'h5C;
      tx_q.push_back(8'hC8); tx_q.push_back(8'h00);
      push_exp(2'b10, 1'b0, 8'h5C);
      set_req(1, 5'd25, 1'b0, 8'h00);
      wait_ack(1);
      repeat (5) @(negedge clk_in);

      // Both held for four transactions: order 0,1,0,1.
      for (int k = 0; k < 2; k++) begin
         tx_q.push_back(8'h8A); tx_q.push_back(8'h20);
         push_exp(2'b01, 1'b0, 8'h5C);
         tx_q.push_back(8'hC8); tx_q.push_back(8'h00);
         push_exp(2'b10, 1'b0, 8'h5C);
      end
      set_req(0, 5'd17, 1'b1, 8'h20);
      set_req(1, 5'd25, 1'b0, 8'h00);
      begin
         int acks = 0;
         int n    = 0;
         while (acks < 4 && n < 4 * BUDGET) begin
            @(negedge clk_in);
            n++;
            if (ack_out != 2'b00) acks++;
         end
         if (acks < 4) fail_now("rr_ack_wait_expired");
         req_in = 2'b00;
      end
      repeat (5) @(negedge clk_in);

      // Byte engine silent: timeout on the command byte.
      model_never = 1'b1;
      tx_q.push_back(8'h8A);
      push_exp(2'b01, 1'b1, 8'hFF);
      set_req(0, 5'd17, 1'b1, 8'h20);
      wait_ack(0);
      repeat (5) @(negedge clk_in);
      model_never = 1'b0;

      // Done lands exactly on the timeout cycle: done wins on both bytes.
      model_dly = TIMEOUT - 1;
      model_rx  = 8'hA7;
      tx_q.push_back(8'h18); tx_q.push_back(8'h00);
      push_exp(2'b10, 1'b0, 8'hA7);
      set_req(1, 5'd3, 1'b0, 8'h00);
      wait_ack(1);
      repeat (5) @(negedge clk_in);

      // Reset in the middle of the data byte of a requester-0 write.
      model_dly = 8;
      model_rx  = 8'h5C;
      tx_q.push_back(8'h8A); tx_q.push_back(8'h20);
      set_req(0, 5'd17, 1'b1, 8'h20);
      begin
         int starts = 0;
         int n      = 0;
         while (starts < 2 && n < BUDGET) begin
            @(negedge clk_in);
            n++;
            if (spi_start_out) starts++;
         end
         if (starts < 2) fail_now("data_start_wait_expired");
      end
      repeat (3) @(negedge clk_in);
      rst_in = 1'b0;
      req_in = 2'b00;
      @(negedge clk_in);
      rst_in = 1'b1;
      chk("midrst_ss", ss_out, 1'b1);
      chk("midrst_busy", busy_out, 1'b0);
      chk("midrst_ack", ack_out, 2'b00);
      chk("midrst_start", spi_start_out, 1'b0);
      chk("midrst_rdata", rdata_out, 8'h00);
      repeat (15) @(negedge clk_in);

      // Simultaneous requests after reset: requester 0 first.
      tx_q.push_back(8'h8A); tx_q.push_back(8'h20);
      push_exp(2'b01, 1'b0, 8'h00);
      tx_q.push_back(8'hC8); tx_q.push_back(8'h00);
      push_exp(2'b10, 1'b0, 8'h5C);
      set_req(0, 5'd17, 1'b1, 8'h20);
      set_req(1, 5'd25, 1'b0, 8'h00);
      fork
         wait_ack(0);
         wait_ack(1);
      join
      repeat (10) @(negedge clk_in);

      chk("exp_queue_drained", exp_q.size(), 0);
      chk("tx_queue_drained", tx_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
